// File: rtl/conv_pkg.sv
// Shared constants and types for the window multiply-accumulate stage.
package conv_pkg;

    localparam int DATA_W      = 16;
    localparam int FRAC_BITS   = 8;
    localparam int WEIGHT_SIZE = 25;
    localparam int LANES       = 5;
    localparam int ACC_W       = 2 * DATA_W + $clog2(WEIGHT_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } mac_state_t;

    typedef logic signed [DATA_W-1:0] win_t [WEIGHT_SIZE];

endpackage

// File: rtl/window_mac_dot5.sv
// Five-lane slice: registers the pixels, multiplies by the held weights,
// then sums the five products. Every register advances only while en is high.
module dot5
    import conv_pkg::*;
#(
    parameter int data_width = DATA_W
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic signed [data_width-1:0]   pix [LANES],
    input  logic signed [data_width-1:0]   wt  [LANES],
    output logic signed [2*data_width+2:0] sum
);

    localparam int PW = 2 * data_width;
    localparam int SW = 2 * data_width + 3;

    logic signed [data_width-1:0] pix_r  [LANES];
    logic signed [PW-1:0]         prod_r [LANES];
    logic signed [SW-1:0]         sum_r;
    logic signed [SW-1:0]         sum_s;

    // Lane adder tree feeding the partial-sum register
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_s = sum_s + SW'(prod_r[k]);
        end
    end

    // Window capture, product and partial-sum stages
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < LANES; k++) begin
                pix_r[k]  <= pix[k];
                prod_r[k] <= pix_r[k] * wt[k];
            end
            sum_r <= sum_s;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/window_mac.sv
// 5x5 window dot product with serially loaded weights and bias; rounds,
// saturates and optionally clamps negatives before presenting each result.
module window_mac
    import conv_pkg::*;
#(
    parameter int data_width  = DATA_W,
    parameter int weight_size = WEIGHT_SIZE,
    parameter int frac_bits   = FRAC_BITS,
    parameter int relu_en     = 1,
    parameter int acc_width   = 2 * data_width + $clog2(weight_size) + 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         w_start,
    input  logic                         w_valid,
    input  logic signed [data_width-1:0] w_data,
    output logic                         w_ready,
    output logic                         weights_loaded,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [data_width-1:0] win [weight_size],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [data_width-1:0] out_data,
    output logic                         busy
);

    localparam int CNT_W  = $clog2(weight_size + 1);
    localparam int SW     = 2 * data_width + 3;
    localparam int NSLICE = weight_size / LANES;
    localparam logic signed [acc_width-1:0] HALF    = acc_width'(1'b1) << (frac_bits - 1);
    localparam logic signed [acc_width-1:0] SAT_MAX =
        {{(acc_width-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
    localparam logic signed [acc_width-1:0] SAT_MIN =
        {{(acc_width-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

    mac_state_t                   state_r, next_state_s;
    logic [CNT_W-1:0]             cnt_r;
    logic                         weights_loaded_r, w_ready_r, out_valid_r;
    logic [3:0]                   stage_v_r;
    logic signed [data_width-1:0] weight_r [weight_size];
    logic signed [data_width-1:0] bias_r, out_data_r, res_s, relu_s;
    logic signed [acc_width-1:0]  total_s, total_r, shr_s;
    logic signed [SW-1:0]         part_s [NSLICE];
    logic stall_s, adv_s, busy_s, in_ready_s, accept_s;
    logic load_beat_s, last_beat_s, bias_beat_s;

    assign stall_s     = out_valid_r && !out_ready;
    assign adv_s       = !stall_s;
    assign busy_s      = (|stage_v_r) || out_valid_r;
    assign accept_s    = in_valid && in_ready_s;
    assign last_beat_s = (cnt_r == CNT_W'(weight_size));
    assign bias_beat_s = load_beat_s && last_beat_s;

    // Next-state logic; a reload from RUN waits until the pipeline is empty
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: if (w_start) next_state_s = LOAD; else next_state_s = IDLE;
            LOAD: begin
                if (w_start)                        next_state_s = LOAD;
                else if (w_valid && last_beat_s)    next_state_s = RUN;
                else                                next_state_s = LOAD;
            end
            RUN:  if (w_start && !busy_s) next_state_s = LOAD; else next_state_s = RUN;
            default: next_state_s = IDLE;
        endcase
    end

    // State-decoded strobes; a window is refused in the cycle a reload begins
    always_comb begin
        in_ready_s  = 1'b0;
        load_beat_s = 1'b0;
        case (state_r)
            LOAD: load_beat_s = w_valid && !w_start;
            RUN:  in_ready_s  = !stall_s && !(w_start && !busy_s);
            default: begin
                in_ready_s  = 1'b0;
                load_beat_s = 1'b0;
            end
        endcase
    end

    // FSM state, load counter and status flags
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r          <= IDLE;
            cnt_r            <= '0;
            weights_loaded_r <= 1'b0;
            w_ready_r        <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            w_ready_r <= (next_state_s == LOAD);
            if (w_start && next_state_s == LOAD) begin
                cnt_r            <= '0;
                weights_loaded_r <= 1'b0;
            end else if (bias_beat_s) begin
                cnt_r            <= '0;
                weights_loaded_r <= 1'b1;
            end else if (load_beat_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Coefficient storage survives reset; weights_loaded tells whether it is usable
    always_ff @(posedge clk) begin
        if (load_beat_s) begin
            for (int k = 0; k < weight_size; k++) begin
                if (cnt_r == CNT_W'(k)) weight_r[k] <= w_data;
            end
            if (last_beat_s) bias_r <= w_data;
        end
    end

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        logic signed [data_width-1:0] pix_s [LANES];
        logic signed [data_width-1:0] wt_s  [LANES];

        // Route this slice's five window elements and weights
        always_comb begin
            for (int j = 0; j < LANES; j++) begin
                pix_s[j] = win[g*LANES+j];
                wt_s[j]  = weight_r[g*LANES+j];
            end
        end

        dot5 #(.data_width(data_width)) u_dot5 (
            .clk (clk),
            .en  (adv_s),
            .pix (pix_s),
            .wt  (wt_s),
            .sum (part_s[g])
        );
    end

    // Final accumulation with the bias aligned to the product's binary point
    always_comb begin
        total_s = acc_width'(bias_r) <<< frac_bits;
        for (int g = 0; g < NSLICE; g++) begin
            total_s = total_s + acc_width'(part_s[g]);
        end
    end

    // Round half up, saturate to the output range, optional negative clamp
    always_comb begin
        shr_s = (total_r + HALF) >>> frac_bits;
        if (shr_s > SAT_MAX)      res_s = SAT_MAX[data_width-1:0];
        else if (shr_s < SAT_MIN) res_s = SAT_MIN[data_width-1:0];
        else                      res_s = shr_s[data_width-1:0];
        if ((relu_en != 0) && res_s[data_width-1]) relu_s = '0;
        else                                       relu_s = res_s;
    end

    // Accumulator stage, data only
    always_ff @(posedge clk) begin
        if (adv_s) total_r <= total_s;
    end

    // Stage valids and output register; everything holds while stalled
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stage_v_r   <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (adv_s) begin
            stage_v_r   <= {stage_v_r[2:0], accept_s};
            out_valid_r <= stage_v_r[3];
            if (stage_v_r[3]) out_data_r <= relu_s;
        end
    end

    assign w_ready        = w_ready_r;
    assign weights_loaded = weights_loaded_r;
    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign out_data       = out_data_r;
    assign busy           = busy_s;

endmodule

// File: tb/tb_window_mac.sv
// Directed and randomized checks of window_mac (relu on and off instances)
// against an integer reference model and an in-order result scoreboard.
module tb_window_mac;

    localparam int DW = 16;
    localparam int WS = 25;

    logic clk = 1'b0;
    logic nrst = 1'b0, w_start = 1'b0, w_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [DW-1:0] w_data = '0;
    logic signed [DW-1:0] win [WS];
    logic w_ready1, weights_loaded1, in_ready1, out_valid1, busy1;
    logic w_ready0, weights_loaded0, in_ready0, out_valid0, busy0;
    logic signed [DW-1:0] out_data1, out_data0;

    typedef struct { int r1; int r0; } exp_t;
    exp_t sb[$];
    int   mw [WS];
    int   mb;
    int   tw [WS];
    int   tbias;
    int   n_pass = 0, n_chk = 0, n_fail = 0, n_out = 0;
    bit   last_acc, last_hs;

    always #5 clk = ~clk;

    window_mac #(.relu_en(1)) dut1 (
        .clk(clk), .nrst(nrst), .w_start(w_start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready1), .weights_loaded(weights_loaded1), .in_valid(in_valid),
        .in_ready(in_ready1), .win(win), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .busy(busy1));

    window_mac #(.relu_en(0)) dut0 (
        .clk(clk), .nrst(nrst), .w_start(w_start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready0), .weights_loaded(weights_loaded0), .in_valid(in_valid),
        .in_ready(in_ready0), .win(win), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .busy(busy0));

    // Reference: exact integer dot product, floor((x+128)/256), clip, optional clamp
    function automatic int model(bit relu);
        longint acc = 0;
        for (int k = 0; k < WS; k++) acc += longint'(mw[k]) * longint'(win[k]);
        acc += longint'(mb) * 256;
        acc = (acc + 128) >>> 8;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return int'(acc);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, score results, move past the edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        last_acc = in_valid && in_ready1;
        last_hs  = out_valid1 && out_ready;
        if (out_valid1 && !out_ready) chk("stall_in_ready", in_ready1, 0);
        if (last_acc) begin
            e.r1 = model(1'b1);
            e.r0 = model(1'b0);
            sb.push_back(e);
        end
        if (last_hs) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL extra_output: got %0d expected none", out_data1);
            end else begin
                e = sb.pop_front();
                chk("sb_relu1", out_data1, e.r1);
                chk("sb_relu0", out_data0, e.r0);
                chk("sb_valid0", out_valid0, 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_set();
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        chk("load_w_ready", w_ready1, 1);
        chk("load_wl_clear", weights_loaded1, 0);
        for (int i = 0; i <= WS; i++) begin
            w_valid = 1'b1;
            w_data  = (i < WS) ? DW'(tw[i]) : DW'(tbias);
            chk("load_in_ready", in_ready1, 0);
            if (i == WS) chk("load_wl_before_bias", weights_loaded1, 0);
            step();
        end
        w_valid = 1'b0;
        chk("load_wl_set", weights_loaded1, 1);
        chk("load_w_ready_run", w_ready1, 0);
        mw = tw;
        mb = tbias;
    endtask

    task automatic send();
        in_valid = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 40 && !last_acc; i++) step();
        in_valid = 1'b0;
        chk("accept", last_acc, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (busy1 || sb.size() != 0); i++) step();
        chk("drain_busy", busy1, 0);
        chk("drain_sb", sb.size(), 0);
    endtask

    task automatic fill_win(input int v);
        for (int k = 0; k < WS; k++) win[k] = DW'(v);
    endtask

    task automatic rand_win();
        for (int k = 0; k < WS; k++) win[k] = DW'(int'($urandom_range(4095)) - 2048);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nacc;
        fill_win(0);
        step();
        step();
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_w_ready", w_ready1, 0);
        chk("rst_wl", weights_loaded1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_out_data", out_data1, 0);
        chk("rst_in_ready", in_ready1, 0);
        nrst = 1'b1;
        step();
        chk("idle_in_ready", in_ready1, 0);

        // Unity weights, latency of exactly four edges
        foreach (tw[k]) tw[k] = 256;
        tbias = 0;
        load_set();
        fill_win(256);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        chk("lat_accept", last_acc, 1);
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("lat_out_valid", out_valid1, (i == 4) ? 1 : 0);
        end
        chk("unity_relu1", out_data1, 6400);
        chk("unity_relu0", out_data0, 6400);
        drain();

        // Negative unity weights
        foreach (tw[k]) tw[k] = -256;
        load_set();
        send();
        drain();
        chk("neg_relu1", out_data1, 0);
        chk("neg_relu0", out_data0, -6400);

        // Saturation both ways
        foreach (tw[k]) tw[k] = 32767;
        load_set();
        fill_win(32767);
        send();
        drain();
        chk("satp_relu1", out_data1, 32767);
        chk("satp_relu0", out_data0, 32767);
        fill_win(-32768);
        send();
        drain();
        chk("satn_relu1", out_data1, 0);
        chk("satn_relu0", out_data0, -32768);

        // Rounding boundary and bias path
        foreach (tw[k]) tw[k] = 0;
        tw[0] = 1;
        load_set();
        fill_win(0);
        win[0] = 16'sd128;
        send();
        drain();
        chk("round_up", out_data0, 1);
        win[0] = 16'sd127;
        send();
        drain();
        chk("round_down", out_data0, 0);
        tbias = 512;
        load_set();
        fill_win(0);
        send();
        drain();
        chk("bias_only", out_data1, 512);

        // Random weights, ten back-to-back windows under random backpressure
        foreach (tw[k]) tw[k] = int'($urandom_range(255)) - 128;
        tbias = int'($urandom_range(2047)) - 1024;
        load_set();
        n_out = 0;
        nacc  = 0;
        rand_win();
        in_valid = 1'b1;
        for (int i = 0; i < 400 && nacc < 10; i++) begin
            out_ready = 1'($urandom_range(1));
            step();
            if (last_acc) begin
                nacc++;
                if (nacc < 10) rand_win();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream_accepted", nacc, 10);
        drain();
        chk("stream_outputs", n_out, 10);

        // Reload request while busy is dropped; a later one is honoured
        out_ready = 1'b0;
        rand_win();
        send();
        chk("busy_set", busy1, 1);
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        chk("busy_wstart_ignored", w_ready1, 0);
        chk("busy_wl_kept", weights_loaded1, 1);
        drain();
        foreach (tw[k]) tw[k] = int'($urandom_range(255)) - 128;
        tbias = 0;
        load_set();
        chk("reload_in_ready", in_ready1, 1);
        rand_win();
        send();
        drain();

        // Reset in the middle of a stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_win();
            step();
        end
        in_valid = 1'b0;
        nrst     = 1'b0;
        step();
        chk("mid_rst_out_valid", out_valid1, 0);
        chk("mid_rst_wl", weights_loaded1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_out_valid0", out_valid0, 0);
        sb.delete();
        nrst = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
